// File: rtl/div_seq_32.sv
// Sequential restoring divider: one shared 32-bit ripple subtractor, one quotient bit per cycle.
// Unsigned quotient/remainder with a start/done handshake and a divide-by-zero flag.

module sub_32 (
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic        bin,
    output logic [31:0] diff,
    output logic        bout
);
    logic [32:0] borrow;

    // NOTE: every variable assigned in always_comb gets a value on all paths, so no latch is inferred.
    always_comb begin
        borrow    = '0;
        diff      = '0;
        borrow[0] = bin;
        for (int i = 0; i < 32; i++) begin
            diff[i]     = in0[i] ^ in1[i] ^ borrow[i];
            borrow[i+1] = (~in0[i] & in1[i]) | (~(in0[i] ^ in1[i]) & borrow[i]);
        end
        bout = borrow[32];
    end
endmodule

module div_seq_32 #(
    parameter logic [31:0] DBZ_QUOT = 32'hFFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  count_q, count_d;
    logic [31:0] d_q, d_d;
    logic [31:0] q_q, q_d;
    logic [31:0] r_q, r_d;
    logic [31:0] quotient_q, quotient_d;
    logic [31:0] remainder_q, remainder_d;
    logic        done_q, done_d;
    logic        dbz_q, dbz_d;

    logic [31:0] sub_in0;
    logic [31:0] sub_diff;
    logic        sub_bout;
    logic        ok;
    logic [31:0] r_next;
    logic [31:0] q_next;

    // The partial remainder shifted left by one, with the next dividend bit appended.
    assign sub_in0 = {r_q[30:0], q_q[31]};

    sub_32 u_sub (
        .in0  (sub_in0),
        .in1  (d_q),
        .bin  (1'b0),
        .diff (sub_diff),
        .bout (sub_bout)
    );

    // A set r_q[31] means the shifted value exceeds 32 bits and is therefore larger than any divisor.
    assign ok     = r_q[31] | ~sub_bout;
    assign r_next = ok ? sub_diff : sub_in0;
    assign q_next = {q_q[30:0], ok};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        d_d         = d_q;
        q_d         = q_q;
        r_d         = r_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        done_d      = 1'b0;
        dbz_d       = dbz_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    d_d     = divisor;
                    q_d     = dividend;
                    r_d     = '0;
                    count_d = '0;
                    if (divisor == '0) begin
                        state_d     = DONE;
                        quotient_d  = DBZ_QUOT;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        state_d = RUN;
                        dbz_d   = 1'b0;
                    end
                end
            end
            RUN: begin
                r_d = r_next;
                q_d = q_next;
                if (count_q == 5'd31) begin
                    state_d     = DONE;
                    count_d     = '0;
                    quotient_d  = q_next;
                    remainder_d = r_next;
                    done_d      = 1'b1;
                end else begin
                    count_d = count_q + 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            count_q     <= '0;
            d_q         <= '0;
            q_q         <= '0;
            r_q         <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            done_q      <= 1'b0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            d_q         <= d_d;
            q_q         <= q_d;
            r_q         <= r_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            done_q      <= done_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q == RUN) || (state_q == DONE);
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
endmodule

// File: tb/tb_div_seq_32.sv
// Directed bench for div_seq_32: hand-computed quotient/remainder, latency, hold and reset-abort checks.

module tb_div_seq_32;
    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int n_cmp;
    int n_mis;
    logic [31:0] last_q;
    logic [31:0] last_r;

    div_seq_32 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .quotient    (quotient),
        .remainder   (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Starts a division from IDLE and follows it to done; inputs change on falling edges only.
    task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input logic exp_dbz, input int exp_edges, input logic inject);
        int edges;
        int guard;
        guard = 0;
        while (busy && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check({tag, " idle_before_start"}, {31'b0, busy}, 32'd0);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        @(negedge clk);
        start    = 1'b0;
        dividend = 32'hDEAD_BEEF;
        divisor  = 32'h0000_0000;
        edges    = 1;
        while (!done && edges < 100) begin
            if (edges == 10) begin
                check({tag, " busy_mid_run"}, {31'b0, busy}, 32'd1);
                check({tag, " quot_held_mid_run"}, quotient, last_q);
                check({tag, " rem_held_mid_run"}, remainder, last_r);
                if (inject) begin
                    start    = 1'b1;
                    dividend = 32'd9;
                    divisor  = 32'd2;
                end
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
        end
        check({tag, " done_seen"}, {31'b0, done}, 32'd1);
        check({tag, " latency"}, edges, exp_edges);
        check({tag, " quotient"}, quotient, exp_q);
        check({tag, " remainder"}, remainder, exp_r);
        check({tag, " div_by_zero"}, {31'b0, div_by_zero}, {31'b0, exp_dbz});
        check({tag, " busy_in_done"}, {31'b0, busy}, 32'd1);
        last_q = exp_q;
        last_r = exp_r;
        @(negedge clk);
        check({tag, " done_one_cycle"}, {31'b0, done}, 32'd0);
        check({tag, " busy_after_done"}, {31'b0, busy}, 32'd0);
        check({tag, " quotient_held"}, quotient, exp_q);
    endtask

    initial begin
        n_cmp    = 0;
        n_mis    = 0;
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd77;
        divisor  = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset quotient", quotient, 32'd0);
        check("reset remainder", remainder, 32'd0);
        check("reset flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        rst   = 1'b0;
        start = 1'b0;
        last_q = 32'd0;
        last_r = 32'd0;
        @(negedge clk);

        run_div("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33, 1'b0);
        run_div("max/1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33, 1'b0);
        run_div("max/8000_0001", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33, 1'b0);
        run_div("5/0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1, 1'b0);
        run_div("1000/3 ignore start", 32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, 33, 1'b1);
        run_div("9/2", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 33, 1'b0);
        run_div("7/9", 32'd7, 32'd9, 32'd0, 32'd7, 1'b0, 33, 1'b0);

        // Reset partway through 50/5 must abort the run without a done pulse.
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort quotient", quotient, 32'd0);
        check("abort remainder", remainder, 32'd0);
        check("abort flags", {29'b0, busy, done, div_by_zero}, 32'd0);
        begin
            int seen_done;
            seen_done = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (done || busy) seen_done++;
            end
            check("abort no done", seen_done, 32'd0);
        end
        last_q = 32'd0;
        last_r = 32'd0;
        run_div("50/5 after abort", 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 33, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
